// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core: ALU operation codes, the
// execute-stage control bundle, the bubble constant and a forwarding
// match helper used by the decode/execute boundary.
package riscv_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_EQ  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b1010;

    // Control carried from decode into execute and onwards.
    typedef struct packed {
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic [ALU_OP_W-1:0] operation;
    } ex_ctrl_t;

    // A bubble carries no side effects: every control bit is clear and
    // the operation code is ALU_AND (all zeros).
    localparam ex_ctrl_t BUBBLE = '0;

    // True when a producer writing prod_rd supplies the value for src.
    // x0 is hard-wired to zero and is never forwarded.
    function automatic logic fwd_hit(input logic       reg_write,
                                     input logic [4:0] prod_rd,
                                     input logic [4:0] src);
        return reg_write && (prod_rd != 5'd0) && (prod_rd == src);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard check between the decode instruction and the
// instructions already in flight. Behaviour depends on ID_EX_FORWARDING_EN:
// with forwarding only a load followed by a dependent instruction stalls;
// without it any dependency on an EX or MEM producer stalls (WB is covered
// by the write-through register file).
module hazard_detect (
    input  logic       e_valid,
    input  logic       e_mem_read,
    input  logic       e_reg_write,
    input  logic [4:0] e_rd,
    input  logic       m_reg_write,
    input  logic [4:0] m_rd,
    input  logic       d_valid,
    input  logic [4:0] d_rs1,
    input  logic [4:0] d_rs2,
    input  logic       flush,
    output logic       hazard,
    output logic       stall
);

`ifdef ID_EX_FORWARDING_EN
    logic unused_hz;
    assign unused_hz = ^{e_reg_write, m_reg_write, m_rd};

    // Only a load in execute cannot be forwarded in time.
    assign hazard = e_valid & e_mem_read & (e_rd != 5'd0) & d_valid &
                    ((e_rd == d_rs1) | (e_rd == d_rs2));
`else
    logic unused_hz;
    logic rs1_dep;
    logic rs2_dep;
    assign unused_hz = e_mem_read;

    // Without forwarding every in-flight producer ahead of WB blocks decode.
    assign rs1_dep = (d_rs1 != 5'd0) &
                     ((e_valid & e_reg_write & (e_rd == d_rs1)) |
                      (m_reg_write & (m_rd == d_rs1)));
    assign rs2_dep = (d_rs2 != 5'd0) &
                     ((e_valid & e_reg_write & (e_rd == d_rs2)) |
                      (m_reg_write & (m_rd == d_rs2)));
    assign hazard  = d_valid & (rs1_dep | rs2_dep);
`endif

    // A flushed decode instruction is discarded, so it never needs holding.
    assign stall = hazard & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and hazard handling.
// Optional feature macro: ID_EX_FORWARDING_EN (forwarding muxes from
// EX/MEM and MEM/WB; when undefined operands come only from the register
// file and hazards are resolved purely by stalling).
//
// Flow control: Stall is a hold request to PC and IF/ID, valid in the same
// cycle it is raised. While Stall is high the decode instruction is not
// consumed and a bubble (E_Valid=0, all control 0) enters this register;
// the decode instruction is taken on the first edge where Stall is low.
// Flush discards the decode instruction in favour of a bubble.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int PC_WIDTH      = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Flush,
    input  logic                     D_Valid,
    input  logic [DATA_WIDTH-1:0]    D_Rs1Data,
    input  logic [DATA_WIDTH-1:0]    D_Rs2Data,
    input  logic [DATA_WIDTH-1:0]    D_Imm,
    input  logic [4:0]               D_Rs1,
    input  logic [4:0]               D_Rs2,
    input  logic [4:0]               D_Rd,
    input  logic [OPCODE_LENGTH-1:0] D_Operation,
    input  logic                     D_ALUSrc,
    input  logic                     D_MemRead,
    input  logic                     D_MemWrite,
    input  logic                     D_RegWrite,
    input  logic                     D_MemtoReg,
    input  logic [PC_WIDTH-1:0]      D_PcFour,
    input  logic [4:0]               M_Rd,
    input  logic                     M_RegWrite,
    input  logic [DATA_WIDTH-1:0]    M_Result,
    input  logic [4:0]               W_Rd,
    input  logic                     W_RegWrite,
    input  logic [DATA_WIDTH-1:0]    W_Result,
    output logic                     Stall,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [PC_WIDTH-1:0]      PcFour,
    output logic                     E_Valid,
    output logic                     E_RegWrite,
    output logic                     E_MemRead,
    output logic                     E_MemWrite,
    output logic                     E_MemtoReg,
    output logic [4:0]               E_Rd,
    output logic [DATA_WIDTH-1:0]    E_StoreData
);

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [DATA_WIDTH-1:0] imm;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        ex_ctrl_t              ctrl;
        logic [PC_WIDTH-1:0]   pc_four;
    } id_ex_t;

    id_ex_t                q;
    id_ex_t                d_word;
    id_ex_t                bubble_word;
    logic                  hazard;
    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;

    hazard_detect u_hazard (
        .e_valid     (q.valid),
        .e_mem_read  (q.ctrl.mem_read),
        .e_reg_write (q.ctrl.reg_write),
        .e_rd        (q.rd),
        .m_reg_write (M_RegWrite),
        .m_rd        (M_Rd),
        .d_valid     (D_Valid),
        .d_rs1       (D_Rs1),
        .d_rs2       (D_Rs2),
        .flush       (Flush),
        .hazard      (hazard),
        .stall       (Stall)
    );

    // Gather the decode-side fields into one register word.
    always_comb begin
        d_word                 = '0;
        d_word.valid           = D_Valid;
        d_word.rs1_data        = D_Rs1Data;
        d_word.rs2_data        = D_Rs2Data;
        d_word.imm             = D_Imm;
        d_word.rs1             = D_Rs1;
        d_word.rs2             = D_Rs2;
        d_word.rd              = D_Rd;
        d_word.ctrl.mem_read   = D_MemRead;
        d_word.ctrl.mem_write  = D_MemWrite;
        d_word.ctrl.reg_write  = D_RegWrite;
        d_word.ctrl.mem_to_reg = D_MemtoReg;
        d_word.ctrl.alu_src    = D_ALUSrc;
        d_word.ctrl.operation  = D_Operation;
        d_word.pc_four         = D_PcFour;
    end

    // A bubble zeroes every field, so its rs/rd addresses are x0 and it can
    // never match a forwarding or hazard compare.
    always_comb begin
        bubble_word      = '0;
        bubble_word.ctrl = BUBBLE;
    end

    // Pipeline register: reset beats bubble, bubble beats a normal load.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (Flush || hazard) begin
            q <= bubble_word;
        end else begin
            q <= d_word;
        end
    end

`ifdef ID_EX_FORWARDING_EN
    // Operand bypass: the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        fwd_a = q.rs1_data;
        fwd_b = q.rs2_data;
        if (fwd_hit(M_RegWrite, M_Rd, q.rs1)) begin
            fwd_a = M_Result;
        end else if (fwd_hit(W_RegWrite, W_Rd, q.rs1)) begin
            fwd_a = W_Result;
        end
        if (fwd_hit(M_RegWrite, M_Rd, q.rs2)) begin
            fwd_b = M_Result;
        end else if (fwd_hit(W_RegWrite, W_Rd, q.rs2)) begin
            fwd_b = W_Result;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{M_Result, W_Rd, W_RegWrite, W_Result};
    assign fwd_a      = q.rs1_data;
    assign fwd_b      = q.rs2_data;
`endif

    assign SrcA        = fwd_a;
    assign SrcB        = q.ctrl.alu_src ? q.imm : fwd_b;
    assign E_StoreData = fwd_b;
    assign Operation   = q.ctrl.operation;
    assign PcFour      = q.pc_four;
    assign E_Valid     = q.valid;
    assign E_RegWrite  = q.ctrl.reg_write;
    assign E_MemRead   = q.ctrl.mem_read;
    assign E_MemWrite  = q.ctrl.mem_write;
    assign E_MemtoReg  = q.ctrl.mem_to_reg;
    assign E_Rd        = q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage. Builds with or without ID_EX_FORWARDING_EN;
// the build-specific dependency sequences are selected the same way.
`timescale 1ns/1ps
module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int PW = 9;
    localparam int EW = 5 + 5 + OW + PW;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset, Flush, D_Valid;
    logic [DW-1:0] D_Rs1Data, D_Rs2Data, D_Imm;
    logic [4:0]    D_Rs1, D_Rs2, D_Rd;
    logic [OW-1:0] D_Operation;
    logic          D_ALUSrc, D_MemRead, D_MemWrite, D_RegWrite, D_MemtoReg;
    logic [PW-1:0] D_PcFour;
    logic [4:0]    M_Rd, W_Rd;
    logic          M_RegWrite, W_RegWrite;
    logic [DW-1:0] M_Result, W_Result;
    logic          Stall;
    logic [DW-1:0] SrcA, SrcB, E_StoreData;
    logic [OW-1:0] Operation;
    logic [PW-1:0] PcFour;
    logic          E_Valid, E_RegWrite, E_MemRead, E_MemWrite, E_MemtoReg;
    logic [4:0]    E_Rd;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .PC_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .Flush(Flush), .D_Valid(D_Valid),
        .D_Rs1Data(D_Rs1Data), .D_Rs2Data(D_Rs2Data), .D_Imm(D_Imm),
        .D_Rs1(D_Rs1), .D_Rs2(D_Rs2), .D_Rd(D_Rd), .D_Operation(D_Operation),
        .D_ALUSrc(D_ALUSrc), .D_MemRead(D_MemRead), .D_MemWrite(D_MemWrite),
        .D_RegWrite(D_RegWrite), .D_MemtoReg(D_MemtoReg), .D_PcFour(D_PcFour),
        .M_Rd(M_Rd), .M_RegWrite(M_RegWrite), .M_Result(M_Result),
        .W_Rd(W_Rd), .W_RegWrite(W_RegWrite), .W_Result(W_Result),
        .Stall(Stall), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .PcFour(PcFour), .E_Valid(E_Valid), .E_RegWrite(E_RegWrite),
        .E_MemRead(E_MemRead), .E_MemWrite(E_MemWrite), .E_MemtoReg(E_MemtoReg),
        .E_Rd(E_Rd), .E_StoreData(E_StoreData)
    );

    // ---------------- vector record ----------------
    typedef struct packed {
        logic          reset, flush, d_valid;
        logic [4:0]    rs1, rs2, rd;
        logic [DW-1:0] rs1_data, rs2_data, imm;
        logic [OW-1:0] op;
        logic          alu_src, mem_read, mem_write, reg_write, mem_to_reg;
        logic [PW-1:0] pc;
        logic [4:0]    m_rd, w_rd;
        logic          m_rw, w_rw;
        logic [DW-1:0] m_res, w_res;
        logic          bub, stall;
        logic [DW-1:0] srca, srcb, store;
    } vec_t;

    function automatic vec_t dec(input logic v, input logic [4:0] rs1, rs2, rd,
                                 input logic [DW-1:0] d1, d2, imm,
                                 input logic [OW-1:0] op,
                                 input logic as, mr, mw, rw, m2r,
                                 input logic [PW-1:0] pc);
        vec_t r;
        r = '0;
        r.d_valid = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.rs1_data = d1; r.rs2_data = d2; r.imm = imm; r.op = op;
        r.alu_src = as; r.mem_read = mr; r.mem_write = mw;
        r.reg_write = rw; r.mem_to_reg = m2r; r.pc = pc;
        return r;
    endfunction

    function automatic vec_t env(input vec_t v, input logic fl, rst,
                                 input logic [4:0] mrd, input logic mrw,
                                 input logic [DW-1:0] mres,
                                 input logic [4:0] wrd, input logic wrw,
                                 input logic [DW-1:0] wres);
        vec_t r;
        r = v;
        r.flush = fl; r.reset = rst;
        r.m_rd = mrd; r.m_rw = mrw; r.m_res = mres;
        r.w_rd = wrd; r.w_rw = wrw; r.w_res = wres;
        return r;
    endfunction

    function automatic vec_t ex(input vec_t v, input logic bub, st,
                                input logic [DW-1:0] a, b, s);
        vec_t r;
        r = v;
        r.bub = bub; r.stall = st; r.srca = a; r.srcb = b; r.store = s;
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int step     = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h expected=%h", name, step, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] e_actual();
        return {E_Valid, E_RegWrite, E_MemRead, E_MemWrite, E_MemtoReg, E_Rd, Operation, PcFour};
    endfunction

    // ---------------- driver ----------------
    task automatic drive_zero();
        Flush = 0; D_Valid = 0; D_Rs1Data = '0; D_Rs2Data = '0; D_Imm = '0;
        D_Rs1 = '0; D_Rs2 = '0; D_Rd = '0; D_Operation = '0; D_ALUSrc = 0;
        D_MemRead = 0; D_MemWrite = 0; D_RegWrite = 0; D_MemtoReg = 0; D_PcFour = '0;
        M_Rd = '0; M_RegWrite = 0; M_Result = '0; W_Rd = '0; W_RegWrite = 0; W_Result = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_zero();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_ereg", DW'(e_actual()), '0);
        chk("reset_stall", DW'(Stall), '0);
    endtask

    // Drive one cycle, check the combinational outputs, then check what the
    // register captured at the following edge.
    task automatic run_vec(input vec_t v);
        logic [EW-1:0] e_exp;
        @(negedge clk);
        reset = v.reset; Flush = v.flush; D_Valid = v.d_valid;
        D_Rs1 = v.rs1; D_Rs2 = v.rs2; D_Rd = v.rd;
        D_Rs1Data = v.rs1_data; D_Rs2Data = v.rs2_data; D_Imm = v.imm;
        D_Operation = v.op; D_ALUSrc = v.alu_src; D_MemRead = v.mem_read;
        D_MemWrite = v.mem_write; D_RegWrite = v.reg_write; D_MemtoReg = v.mem_to_reg;
        D_PcFour = v.pc;
        M_Rd = v.m_rd; M_RegWrite = v.m_rw; M_Result = v.m_res;
        W_Rd = v.w_rd; W_RegWrite = v.w_rw; W_Result = v.w_res;
        #2;
        chk("stall", DW'(Stall), DW'(v.stall));
        chk("srca", SrcA, v.srca);
        chk("srcb", SrcB, v.srcb);
        chk("store_data", E_StoreData, v.store);
        exp_q.push_back(v.bub ? '0 : {v.d_valid, v.reg_write, v.mem_read, v.mem_write,
                                      v.mem_to_reg, v.rd, v.op, v.pc});
        @(posedge clk);
        #1;
        e_exp = exp_q.pop_front();
        chk("ex_reg", DW'(e_actual()), DW'(e_exp));
        step++;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- test ----------------
    vec_t tbl[7];
    vec_t nop;
    vec_t v;

    initial begin
        reset = 1'b1;
        drive_zero();
        nop = dec(0, 0, 0, 0, 0, 0, 0, ALU_AND, 0, 0, 0, 0, 0, 0);

        // Independent instructions, operand muxing, flush and an invalid slot;
        // none of these carry a dependency, so both builds agree.
        tbl[0] = ex(env(dec(1, 1, 2, 3, 'h11, 'h22, 'h7, ALU_ADD, 0, 0, 0, 1, 0, 'h004),
                        0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0);
        tbl[1] = ex(env(dec(1, 1, 0, 4, 'h11, 0, 'h100, ALU_ADD, 1, 0, 0, 1, 0, 'h008),
                        0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 'h11, 'h22, 'h22);
        tbl[2] = ex(env(dec(1, 1, 2, 0, 'h11, 'h22, 'h40, ALU_ADD, 1, 0, 1, 0, 0, 'h00C),
                        0, 0, 3, 1, 'h33, 0, 0, 0), 0, 0, 'h11, 'h100, 0);
        tbl[3] = ex(env(dec(1, 10, 11, 9, 'hF0F0, 'h0FF0, 0, ALU_XOR, 0, 0, 0, 1, 0, 'h010),
                        0, 0, 4, 1, 'h111, 3, 1, 'h33), 0, 0, 'h11, 'h40, 'h22);
        tbl[4] = ex(env(dec(1, 1, 2, 12, 'h11, 'h22, 0, ALU_SUB, 0, 0, 0, 1, 0, 'h014),
                        1, 0, 0, 0, 0, 4, 1, 'h111), 1, 0, 'hF0F0, 'h0FF0, 'h0FF0);
        tbl[5] = ex(env(dec(0, 0, 0, 13, 0, 0, 0, ALU_AND, 0, 0, 0, 0, 0, 'h018),
                        0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0);
        tbl[6] = ex(env(dec(1, 1, 0, 8, 'h11, 0, 0, ALU_ADD, 1, 1, 0, 1, 1, 'h01C),
                        0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Load-use: lw x8 is now in execute, decode reads x8.
        v = dec(1, 8, 2, 9, 0, 'h22, 0, ALU_ADD, 0, 0, 0, 1, 0, 'h020);
        run_vec(ex(v, 1, 1, 'h11, 0, 0));
`ifdef ID_EX_FORWARDING_EN
        run_vec(ex(env(v, 0, 0, 8, 1, 'h888, 0, 0, 0), 0, 0, 0, 0, 0));
        run_vec(ex(env(nop, 0, 0, 0, 0, 0, 8, 1, 'h888), 0, 0, 'h888, 'h22, 'h22));
`else
        run_vec(ex(env(v, 0, 0, 8, 1, 'h888, 0, 0, 0), 1, 1, 0, 0, 0));
        v.rs1_data = 'h888;
        run_vec(ex(env(v, 0, 0, 0, 0, 0, 8, 1, 'h888), 0, 0, 0, 0, 0));
        run_vec(ex(nop, 0, 0, 'h888, 'h22, 'h22));
`endif

        // Flush together with a load-use condition.
        run_vec(ex(dec(1, 1, 0, 8, 'h11, 0, 'h8, ALU_ADD, 1, 1, 0, 1, 1, 'h040), 0, 0, 0, 0, 0));
        v = dec(1, 8, 2, 9, 0, 'h22, 0, ALU_ADD, 0, 0, 0, 1, 0, 'h044);
        run_vec(ex(env(v, 1, 0, 0, 0, 0, 0, 0, 0), 1, 0, 'h11, 'h8, 0));

        // Reset while stalled: Stall is still high this cycle, clear after.
        run_vec(ex(dec(1, 1, 0, 8, 'h11, 0, 'h8, ALU_ADD, 1, 1, 0, 1, 1, 'h048), 0, 0, 0, 0, 0));
        v = dec(1, 8, 2, 9, 0, 'h22, 0, ALU_ADD, 0, 0, 0, 1, 0, 'h04C);
        run_vec(ex(env(v, 0, 1, 0, 0, 0, 0, 0, 0), 1, 1, 'h11, 'h8, 0));
        run_vec(ex(v, 0, 0, 0, 0, 0));

        // Reset during a valid store with an immediate.
        v = dec(1, 1, 2, 0, 'h11, 'h22, 'h4, ALU_ADD, 1, 0, 1, 0, 0, 'h050);
        run_vec(ex(env(v, 0, 1, 0, 0, 0, 0, 0, 0), 1, 0, 0, 'h22, 'h22));
        run_vec(ex(nop, 0, 0, 0, 0, 0));

        do_reset();
`ifdef ID_EX_FORWARDING_EN
        // Back-to-back add: x5 forwarded from EX/MEM.
        run_vec(ex(dec(1, 1, 2, 5, 'hC, 'h4, 0, ALU_ADD, 0, 0, 0, 1, 0, 'h060), 0, 0, 0, 0, 0));
        run_vec(ex(dec(1, 5, 1, 6, 0, 'h3, 0, ALU_ADD, 0, 0, 0, 1, 0, 'h064), 0, 0, 'hC, 'h4, 'h4));
        run_vec(ex(env(nop, 0, 0, 5, 1, 'h10, 0, 0, 0), 0, 0, 'h10, 'h3, 'h3));
        // Double match: M beats W on both operands.
        run_vec(ex(dec(1, 7, 7, 10, 'h1, 'h1, 0, ALU_AND, 0, 0, 0, 1, 0, 'h070), 0, 0, 0, 0, 0));
        run_vec(ex(env(nop, 0, 0, 7, 1, 'hAA, 7, 1, 'hBB), 0, 0, 'hAA, 'hAA, 'hAA));
        // x0 never forwards; rs2 picks up the W result.
        run_vec(ex(dec(1, 0, 3, 11, 0, 'h5, 0, ALU_EQ, 0, 0, 0, 1, 0, 'h078), 0, 0, 0, 0, 0));
        run_vec(ex(env(nop, 0, 0, 0, 1, 'hFF, 3, 1, 'hBB), 0, 0, 0, 'hBB, 'hBB));
`else
        // Back-to-back dependency: two bubbles, then the written value.
        run_vec(ex(dec(1, 1, 2, 5, 'hC, 'h4, 0, ALU_ADD, 0, 0, 0, 1, 0, 'h060), 0, 0, 0, 0, 0));
        v = dec(1, 5, 0, 6, 0, 0, 0, ALU_ADD, 0, 0, 0, 1, 0, 'h064);
        run_vec(ex(v, 1, 1, 'hC, 'h4, 'h4));
        run_vec(ex(env(v, 0, 0, 5, 1, 'h10, 0, 0, 0), 1, 1, 0, 0, 0));
        v.rs1_data = 'h10;
        run_vec(ex(env(v, 0, 0, 0, 0, 0, 5, 1, 'h10), 0, 0, 0, 0, 0));
        run_vec(ex(nop, 0, 0, 'h10, 0, 0));
        // Distance two: one bubble.
        run_vec(ex(dec(1, 1, 2, 5, 'hC, 'h4, 0, ALU_ADD, 0, 0, 0, 1, 0, 'h070), 0, 0, 0, 0, 0));
        run_vec(ex(dec(1, 1, 2, 7, 'h1, 'h2, 0, ALU_ADD, 0, 0, 0, 1, 0, 'h074), 0, 0, 'hC, 'h4, 'h4));
        v = dec(1, 5, 0, 6, 0, 0, 0, ALU_ADD, 0, 0, 0, 1, 0, 'h078);
        run_vec(ex(env(v, 0, 0, 5, 1, 'h10, 0, 0, 0), 1, 1, 'h1, 'h2, 'h2));
        v.rs1_data = 'h10;
        run_vec(ex(env(v, 0, 0, 0, 0, 0, 5, 1, 'h10), 0, 0, 0, 0, 0));
        run_vec(ex(nop, 0, 0, 'h10, 0, 0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
